noc_input_buffer: RTL and testbench
===================================

# noc_input_buffer

Parametrised per-port input buffer for the mesh router: stores incoming flits in a DEPTH-entry FIFO, performs XY route computation on each head flit, and presents the packet to the switch stage with a valid/ready handshake and a held output-port route. Reports packet-level buffer status using the router's SENT / RECEIVED / FILLING / EMPTY encoding. One instance sits on each router input port, between the upstream link and the switch allocator.

## Interface
Parameters:
- FLIT_SIZE, 19, flit width; bit [FLIT_SIZE-1] is valid, bits [FLIT_SIZE-2:FLIT_SIZE-3] are type, the remainder is data.
- DEPTH, 8, FIFO entries; power of two, at least 2.
- ADDR_BITS, (FLIT_SIZE-3)/2, width of each of xaddr and yaddr; in a head flit xaddr is the upper half of data and yaddr is the lower half.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- cfg_x  in  ADDR_BITS  this router's X coordinate; static after reset
- cfg_y  in  ADDR_BITS  this router's Y coordinate; static after reset
- in_flit  in  FLIT_SIZE  upstream flit
- in_valid  in  1  upstream flit valid
- in_ready  out  1  buffer can accept; equals !full
- out_flit  out  FLIT_SIZE  FIFO head flit
- out_valid  out  1  head flit is routed and offered to the switch
- out_ready  in  1  switch accepts out_flit
- out_port  out  3  route: LOCAL=0, NORTH=1, SOUTH=2, EAST=3, WEST=4, NONE=5
- buf_status  out  2  PACKET_SENT=0, PACKET_RECEIVED=1, PACKET_FILLING=2, PACKET_EMPTY=3
- count  out  $clog2(DEPTH)+1  number of stored flits
- err  out  1  one-cycle pulse when an orphan flit is dropped
- err_cnt  out  8  saturating orphan count; present only when NOC_IBUF_ERR_CNT_EN is defined

## Operation
- Flit types: HEAD=0, TAIL=1, BODY=2, NONE=3. A packet is HEAD, then zero or more BODY, then TAIL.
- Push: in_valid && in_ready && in_flit valid bit set. A flit with its valid bit clear is discarded and has no effect.
- When full, in_ready=0. No push is accepted while full, even in a cycle where a pop occurs.
- Pop: out_valid && out_ready, or an orphan drop.
- Route FSM has two states, R_IDLE and R_ACTIVE.
- In R_IDLE with the FIFO non-empty:
  - If the head flit is HEAD, compute the XY route and register it into out_port, then go to R_ACTIVE.
  - XY route: dx>cfg_x gives EAST; dx<cfg_x gives WEST; otherwise dy>cfg_y gives NORTH, dy<cfg_y gives SOUTH, else LOCAL.
  - If the head flit is BODY, TAIL or NONE, it is an orphan: pop it and pulse err, staying in R_IDLE.
- In R_ACTIVE, out_valid = !empty. On popping a TAIL, go to R_IDLE and set out_port to NONE.
- A HEAD flit arriving at the FIFO head in R_ACTIVE is forwarded as data. Framing is the sender's responsibility.
- Tail counter: increments on a TAIL push and decrements on a TAIL pop (including a dropped TAIL). Both in the same cycle leaves it unchanged.
- buf_status is registered, with this priority:
  - SENT for exactly one cycle after a cycle that popped a TAIL via handshake;
  - else EMPTY if count==0;
  - else RECEIVED if the tail counter is greater than 0;
  - else FILLING.
- Pointers are $clog2(DEPTH) bits and wrap naturally. count is one bit wider. A simultaneous push and pop leaves count unchanged.

## Timing
- Reset (asynchronous, any time, including mid-packet): pointers=0, count=0, tail counter=0, FSM=R_IDLE, out_valid=0, out_port=NONE, buf_status=EMPTY, err=0, err_cnt=0, in_ready=1. Storage contents are not reset. A partially buffered packet is lost.
- A flit pushed at edge N appears on out_flit after edge N. out_flit is a combinational read of the head entry.
- Head flit: route registered at edge N+1, so out_valid rises after edge N+1 (two-cycle latency).
- Body and tail flits in R_ACTIVE: out_valid after edge N (one-cycle latency). Full throughput is one flit per cycle.
- out_valid and out_flit remain stable until out_ready is sampled high.
- An orphan is dropped at the edge after it reaches the FIFO head. err is high for the following cycle.

## Configuration
- NOC_IBUF_ERR_CNT_EN defined: the err_cnt port exists. It increments on each orphan drop, saturates at 255, and is cleared only by reset.
- NOC_IBUF_ERR_CNT_EN undefined: the err_cnt port and its counter are absent. The err pulse behaviour is unchanged.

## Test plan
- cfg=(2,2); push HEAD(dx=5,dy=1), BODY 0x0AA, BODY 0x055, TAIL with out_ready=1 -> out_port=EAST; out_valid rises 2 cycles after the head push; 4 flits out in order; buf_status=SENT for 1 cycle, then EMPTY; out_port=NONE.
- cfg=(2,2); heads with (2,2), (2,0), (2,4), (0,2) -> out_port LOCAL, SOUTH, NORTH, WEST respectively.
- DEPTH=8, out_ready=0; push 9 flits -> in_ready=0 after the 8th; count=8; 9th flit not stored. Release out_ready -> all 8 flits delivered, count=0, in_ready=1 throughout the drain.
- Push BODY then TAIL with no head -> err pulses twice, both flits dropped, out_valid stays 0, buf_status=EMPTY; err_cnt=2 when NOC_IBUF_ERR_CNT_EN is defined.
- Push HEAD+BODY with out_ready=0 -> buf_status=FILLING; push TAIL -> RECEIVED. Assert rst_n=0 mid-drain -> count=0, out_valid=0, out_port=NONE, buf_status=EMPTY immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/noc_input_buffer.sv
// Per-port router input buffer: DEPTH-entry flit FIFO, XY route on head flits, packet status.
// Optional saturating orphan counter on err_cnt when NOC_IBUF_ERR_CNT_EN is defined.
//
// state    | meaning
// R_IDLE   | waiting for a HEAD at the FIFO head; non-HEAD flits there are orphans and dropped
// R_ACTIVE | route held on out_port; flits forwarded until the TAIL is handed off
module noc_input_buffer #(
  parameter int FLIT_SIZE = 19,
  parameter int DEPTH     = 8,
  parameter int ADDR_BITS = (FLIT_SIZE - 3) / 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [ADDR_BITS-1:0]      cfg_x,
  input  logic [ADDR_BITS-1:0]      cfg_y,
  input  logic [FLIT_SIZE-1:0]      in_flit,
  input  logic                      in_valid,
  output logic                      in_ready,
  output logic [FLIT_SIZE-1:0]      out_flit,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [2:0]                out_port,
  output logic [1:0]                buf_status,
  output logic [$clog2(DEPTH):0]    count,
  output logic                      err
`ifdef NOC_IBUF_ERR_CNT_EN
  ,
  output logic [7:0]                err_cnt
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  localparam logic [1:0] T_HEAD = 2'd0;
  localparam logic [1:0] T_TAIL = 2'd1;

  localparam logic [2:0] P_LOCAL = 3'd0;
  localparam logic [2:0] P_NORTH = 3'd1;
  localparam logic [2:0] P_SOUTH = 3'd2;
  localparam logic [2:0] P_EAST  = 3'd3;
  localparam logic [2:0] P_WEST  = 3'd4;
  localparam logic [2:0] P_NONE  = 3'd5;

  localparam logic [1:0] S_SENT     = 2'd0;
  localparam logic [1:0] S_RECEIVED = 2'd1;
  localparam logic [1:0] S_FILLING  = 2'd2;
  localparam logic [1:0] S_EMPTY    = 2'd3;

  typedef enum logic {R_IDLE, R_ACTIVE} route_state_e;

  logic [FLIT_SIZE-1:0] mem [DEPTH];
  logic [PW-1:0]        wr_ptr, rd_ptr;
  logic [CW-1:0]        count_nxt, tail_cnt, tail_nxt;
  route_state_e         state, state_nxt;
  logic [2:0]           port_nxt, xy_port;
  logic [1:0]           status_nxt, head_type, in_type;
  logic [ADDR_BITS-1:0] dx, dy;
  logic                 full, empty, push, pop, hs_pop, orphan_drop;
  logic                 tail_push, tail_pop;

  assign empty     = (count == '0);
  assign full      = (count == CW'(DEPTH));
  assign in_ready  = !full;
  assign in_type   = in_flit[FLIT_SIZE-2:FLIT_SIZE-3];
  assign push      = in_valid && in_ready && in_flit[FLIT_SIZE-1];

  assign out_flit  = mem[rd_ptr];
  assign head_type = out_flit[FLIT_SIZE-2:FLIT_SIZE-3];
  assign dx        = out_flit[2*ADDR_BITS-1:ADDR_BITS];
  assign dy        = out_flit[ADDR_BITS-1:0];

  assign out_valid   = (state == R_ACTIVE) && !empty;
  assign hs_pop      = out_valid && out_ready;
  assign orphan_drop = (state == R_IDLE) && !empty && (head_type != T_HEAD);
  assign pop         = hs_pop || orphan_drop;
  assign tail_push   = push && (in_type == T_TAIL);
  assign tail_pop    = pop && (head_type == T_TAIL);

  // X first, then Y
  always_comb begin
    xy_port = P_LOCAL;
    if (dx > cfg_x)      xy_port = P_EAST;
    else if (dx < cfg_x) xy_port = P_WEST;
    else if (dy > cfg_y) xy_port = P_NORTH;
    else if (dy < cfg_y) xy_port = P_SOUTH;
  end

  always_comb begin
    state_nxt = state;
    port_nxt  = out_port;
    case (state)
      R_IDLE: begin
        if (!empty && head_type == T_HEAD) begin
          state_nxt = R_ACTIVE;
          port_nxt  = xy_port;
        end
      end
      R_ACTIVE: begin
        if (hs_pop && head_type == T_TAIL) begin
          state_nxt = R_IDLE;
          port_nxt  = P_NONE;
        end
      end
    endcase
  end

  always_comb begin
    count_nxt = count;
    case ({push, pop})
      2'b10:   count_nxt = count + CW'(1);
      2'b01:   count_nxt = count - CW'(1);
      default: count_nxt = count;
    endcase
    tail_nxt = tail_cnt;
    case ({tail_push, tail_pop})
      2'b10:   tail_nxt = tail_cnt + CW'(1);
      2'b01:   tail_nxt = tail_cnt - CW'(1);
      default: tail_nxt = tail_cnt;
    endcase
    // Status reflects the buffer contents after this edge
    if (hs_pop && head_type == T_TAIL) status_nxt = S_SENT;
    else if (count_nxt == '0)          status_nxt = S_EMPTY;
    else if (tail_nxt != '0)           status_nxt = S_RECEIVED;
    else                               status_nxt = S_FILLING;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      tail_cnt   <= '0;
      state      <= R_IDLE;
      out_port   <= P_NONE;
      buf_status <= S_EMPTY;
      err        <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      count      <= count_nxt;
      tail_cnt   <= tail_nxt;
      state      <= state_nxt;
      out_port   <= port_nxt;
      buf_status <= status_nxt;
      err        <= orphan_drop;
    end
  end

  // Storage is deliberately left out of reset
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_flit;
  end

`ifdef NOC_IBUF_ERR_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                 err_cnt <= '0;
    else if (orphan_drop && err_cnt != 8'hFF)   err_cnt <= err_cnt + 8'd1;
  end
`endif

endmodule

// File: tb/tb_noc_input_buffer.sv
// Scoreboard bench for noc_input_buffer: stimulus queues expected {port, flit}, a negedge monitor checks handoffs.
// Covers NOC_IBUF_ERR_CNT_EN builds too.
module tb_noc_input_buffer;

  localparam int FS = 19;
  localparam logic [1:0] T_HEAD = 2'd0;
  localparam logic [1:0] T_TAIL = 2'd1;
  localparam logic [1:0] T_BODY = 2'd2;

  logic          clk, rst_n;
  logic [7:0]    cfg_x, cfg_y;
  logic [FS-1:0] in_flit, out_flit;
  logic          in_valid, in_ready, out_valid, out_ready, err;
  logic [2:0]    out_port;
  logic [1:0]    buf_status;
  logic [3:0]    count;
`ifdef NOC_IBUF_ERR_CNT_EN
  logic [7:0]    err_cnt;
`endif

  int checks = 0;
  int errors = 0;
  logic [FS+2:0] exp_q[$];

  noc_input_buffer dut (
    .clk(clk), .rst_n(rst_n), .cfg_x(cfg_x), .cfg_y(cfg_y),
    .in_flit(in_flit), .in_valid(in_valid), .in_ready(in_ready),
    .out_flit(out_flit), .out_valid(out_valid), .out_ready(out_ready),
    .out_port(out_port), .buf_status(buf_status), .count(count), .err(err)
`ifdef NOC_IBUF_ERR_CNT_EN
    , .err_cnt(err_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [FS-1:0] mk(input logic [1:0] t, input logic [15:0] d);
    return {1'b1, t, d};
  endfunction

  task automatic push_one(input logic [FS-1:0] f);
    int n = 0;
    while (!in_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    in_flit  = f;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_drain(input int budget);
    int i = 0;
    while (i < budget && !(exp_q.size() == 0 && count == 0)) begin
      @(negedge clk);
      i++;
    end
    check("drain_remaining", exp_q.size(), 0);
  endtask

  always @(negedge clk) begin
    logic [FS+2:0] e;
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_out: got flit %0h port %0d, expected no output", out_flit, out_port);
      end else begin
        e = exp_q.pop_front();
        check("out_flit", out_flit, e[FS-1:0]);
        check("out_port", out_port, e[FS+2:FS]);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [FS-1:0] f, h, t;
    logic flag;
    int err_seen;
    int xs[4], ys[4], ps[4];
    xs = '{2, 2, 2, 0};
    ys = '{2, 0, 4, 2};
    ps = '{0, 2, 1, 4};

    rst_n = 1'b1; cfg_x = 8'd2; cfg_y = 8'd2;
    in_flit = '0; in_valid = 1'b0; out_ready = 1'b0;
    #2 rst_n = 1'b0;
    #6;
    check("rst_count", count, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_port", out_port, 5);
    check("rst_buf_status", buf_status, 3);
    check("rst_err", err, 0);
    check("rst_in_ready", in_ready, 1);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Packet routed EAST, head latency, SENT then EMPTY
    out_ready = 1'b1;
    h = mk(T_HEAD, {8'd5, 8'd1});
    exp_q.push_back({3'd3, h});
    push_one(h);
    @(negedge clk); check("head_lat1_valid", out_valid, 0);
    @(negedge clk); check("head_lat2_valid", out_valid, 1);
    check("head_route_east", out_port, 3);
    @(posedge clk); #1;
    f = mk(T_BODY, 16'h00AA); exp_q.push_back({3'd3, f}); push_one(f);
    f = mk(T_BODY, 16'h0055); exp_q.push_back({3'd3, f}); push_one(f);
    f = mk(T_TAIL, 16'h0123); exp_q.push_back({3'd3, f}); push_one(f);
    @(negedge clk); check("pkt1_received", buf_status, 1);
    @(negedge clk); check("pkt1_sent", buf_status, 0);
    check("pkt1_port_none", out_port, 5);
    check("pkt1_valid_low", out_valid, 0);
    @(negedge clk); check("pkt1_empty", buf_status, 3);
    check("pkt1_count", count, 0);
    check("pkt1_drained", exp_q.size(), 0);

    // XY route directions
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) begin
      h = mk(T_HEAD, {xs[i][7:0], ys[i][7:0]});
      t = mk(T_TAIL, 16'h00F0 + 16'(i));
      exp_q.push_back({ps[i][2:0], h});
      exp_q.push_back({ps[i][2:0], t});
      push_one(h);
      push_one(t);
    end
    wait_drain(100);

    // Fill to DEPTH, 9th flit refused, then drain
    @(posedge clk); #1;
    out_ready = 1'b0;
    for (int i = 0; i < 9; i++) begin
      if (i == 0)      f = mk(T_HEAD, {8'd7, 8'd2});
      else if (i == 7) f = mk(T_TAIL, 16'h0107);
      else             f = mk(T_BODY, 16'h0100 + 16'(i));
      if (i < 8) exp_q.push_back({3'd3, f});
      in_flit = f;
      in_valid = 1'b1;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    @(negedge clk);
    check("full_in_ready", in_ready, 0);
    check("full_count", count, 8);
    check("full_status", buf_status, 1);
    check("full_out_valid", out_valid, 1);
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    flag = 1'b1;
    for (int i = 0; i < 20 && count != 0; i++) begin
      @(negedge clk);
      if (!in_ready) flag = 1'b0;
    end
    check("drain_in_ready_high", flag, 1);
    wait_drain(50);
    check("drain_count", count, 0);
    check("drain_in_ready", in_ready, 1);

    // Orphans: BODY then TAIL without head
    @(posedge clk); #1;
    err_seen = 0;
    flag = 1'b0;
    push_one(mk(T_BODY, 16'h00AA));
    push_one(mk(T_TAIL, 16'h0055));
    repeat (6) begin
      @(negedge clk);
      if (err) err_seen++;
      if (out_valid) flag = 1'b1;
    end
    check("orphan_err_pulses", err_seen, 2);
    check("orphan_no_valid", flag, 0);
    check("orphan_count", count, 0);
    check("orphan_status", buf_status, 3);
`ifdef NOC_IBUF_ERR_CNT_EN
    check("orphan_err_cnt", err_cnt, 2);
`endif

    // FILLING -> RECEIVED, then async reset mid-drain
    @(posedge clk); #1;
    out_ready = 1'b0;
    h = mk(T_HEAD, {8'd3, 8'd2});
    exp_q.push_back({3'd3, h});
    push_one(h);
    f = mk(T_BODY, 16'h0ABC); exp_q.push_back({3'd3, f}); push_one(f);
    @(negedge clk);
    check("filling_status", buf_status, 2);
    check("filling_count", count, 2);
    @(posedge clk); #1;
    f = mk(T_TAIL, 16'h0DEF); exp_q.push_back({3'd3, f}); push_one(f);
    @(negedge clk);
    check("received_status", buf_status, 1);
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    check("arst_count", count, 0);
    check("arst_out_valid", out_valid, 0);
    check("arst_out_port", out_port, 5);
    check("arst_status", buf_status, 3);
    check("arst_in_ready", in_ready, 1);
    check("arst_flits_lost", exp_q.size(), 2);
    exp_q.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Recovery after reset
    h = mk(T_HEAD, {8'd2, 8'd2});
    t = mk(T_TAIL, 16'h0777);
    exp_q.push_back({3'd0, h});
    exp_q.push_back({3'd0, t});
    push_one(h);
    push_one(t);
    wait_drain(50);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
